training_sync: RTL and testbench

Receive-side preamble synchroniser and the successor to the single-threshold training detector. It measures full preamble periods (falling edge to falling edge) on the `training` line and checks every period against the first one within a parametrised tolerance. It then averages the periods and publishes a `clk_div` in the same convention the preamble generator uses (line toggles every `clk_div+1` cycles). It sits between the line input and the deserializer, and it adds a lock flag, an error code, a watchdog timeout and counter-overflow detection.

---
 rtl/training_sync.sv | 165 ++++++++++++++++
 tb/tb_training_sync.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/training_sync.sv
// training_sync: measures preamble periods on the training line, checks each
// period against the first, and recovers the generator's clk_div from the average.
module training_sync #(
    parameter int unsigned PREAMBLE_COUNT = 8,
    parameter int unsigned DIV_WIDTH      = 8,
    parameter int unsigned TOL_SHIFT      = 2,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     enable,
    input  logic                     training,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic [DIV_WIDTH-1:0]     clk_div,
    output logic                     done,
    output logic                     locked,
    output logic [1:0]               err_code,
    output logic                     busy
);

    localparam int unsigned LogN = $clog2(PREAMBLE_COUNT);
    localparam int unsigned PerW = DIV_WIDTH + 1;
    localparam int unsigned SumW = PerW + LogN;

    localparam logic [1:0] ErrOk  = 2'b00;
    localparam logic [1:0] ErrTol = 2'b01;
    localparam logic [1:0] ErrOvf = 2'b10;
    localparam logic [1:0] ErrTmo = 2'b11;

    typedef enum logic [1:0] {StIdle, StWaitEdge, StMeasure} state_e;

    state_e                   state_q;
    logic                     prev_q;
    logic [PerW-1:0]          pc_q;
    logic [PerW-1:0]          ref_q;
    logic [LogN-1:0]          idx_q;
    logic [SumW-1:0]          sum_q;
    logic [TIMEOUT_WIDTH-1:0] timer_q;

    logic                 fall;
    logic [PerW-1:0]      period;
    logic [PerW-1:0]      ref_v;
    logic [PerW-1:0]      diff;
    logic                 tol_err;
    logic                 last_period;
    logic [SumW-1:0]      sum_next;
    logic [PerW-1:0]      avg;
    logic [DIV_WIDTH-1:0] half;
    logic [DIV_WIDTH-1:0] div_new;
    logic                 tmo;

    // Period arithmetic, tolerance test, divider recovery and watchdog compare.
    always_comb begin
        fall        = enable & prev_q & ~training;
        period      = pc_q + 1'b1;
        // The first accepted period becomes the reference for itself and the rest.
        ref_v       = (idx_q == '0) ? period : ref_q;
        diff        = (period >= ref_v) ? (period - ref_v) : (ref_v - period);
        tol_err     = diff > (ref_v >> TOL_SHIFT);
        last_period = idx_q == LogN'(PREAMBLE_COUNT - 1);
        sum_next    = sum_q + SumW'(period);
        avg         = PerW'(sum_next >> LogN);
        half        = DIV_WIDTH'(avg >> 1);
        div_new     = (half == '0) ? '0 : (half - 1'b1);
        tmo         = (timeout_cycles != '0) && (timer_q == (timeout_cycles - 1'b1));
    end

    // Acquisition FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prev_q   <= 1'b0;
            pc_q     <= '0;
            ref_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            timer_q  <= '0;
            clk_div  <= '0;
            done     <= 1'b0;
            locked   <= 1'b0;
            err_code <= ErrOk;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable) begin
                prev_q <= training;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StWaitEdge;
                        busy     <= 1'b1;
                        locked   <= 1'b0;
                        err_code <= ErrOk;
                        timer_q  <= '0;
                        pc_q     <= '0;
                        idx_q    <= '0;
                        sum_q    <= '0;
                    end
                end
                StWaitEdge: begin
                    timer_q <= timer_q + 1'b1;
                    if (tmo) begin
                        state_q  <= StIdle;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ErrTmo;
                    end else if (fall) begin
                        pc_q    <= '0;
                        state_q <= StMeasure;
                    end
                end
                StMeasure: begin
                    timer_q <= timer_q + 1'b1;
                    if (fall) begin
                        pc_q <= '0;
                        if (tol_err) begin
                            state_q  <= StIdle;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ErrTol;
                        end else begin
                            sum_q <= sum_next;
                            idx_q <= idx_q + 1'b1;
                            if (idx_q == '0) begin
                                ref_q <= period;
                            end
                            if (last_period) begin
                                state_q  <= StIdle;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                err_code <= ErrOk;
                                clk_div  <= div_new;
                                locked   <= 1'b1;
                            end else if (tmo) begin
                                state_q  <= StIdle;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                err_code <= ErrTmo;
                            end
                        end
                    end else if (enable && (pc_q == '1)) begin
                        state_q  <= StIdle;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ErrOvf;
                    end else begin
                        if (enable) begin
                            pc_q <= pc_q + 1'b1;
                        end
                        if (tmo) begin
                            state_q  <= StIdle;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ErrTmo;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_training_sync.sv
// Directed bench for training_sync: nominal, half-rate strobe, tolerance,
// timeout, start-ignore, asynchronous abort and counter overflow.
module tb_training_sync;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        enable;
    logic        training;
    logic [15:0] timeout_cycles;
    logic [7:0]  clk_div;
    logic        done;
    logic        locked;
    logic [1:0]  err_code;
    logic        busy;

    // Narrow instance used only for the overflow case.
    logic        start2;
    logic        training2;
    logic [15:0] timeout2;
    logic [3:0]  clk_div2;
    logic        done2;
    logic        locked2;
    logic [1:0]  err_code2;
    logic        busy2;

    int  n_tests;
    int  n_fail;
    bit  half_rate;
    logic done_pre;
    logic busy_pre;

    training_sync dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .enable         (enable),
        .training       (training),
        .timeout_cycles (timeout_cycles),
        .clk_div        (clk_div),
        .done           (done),
        .locked         (locked),
        .err_code       (err_code),
        .busy           (busy)
    );

    training_sync #(
        .DIV_WIDTH (4)
    ) dut_narrow (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start2),
        .enable         (enable),
        .training       (training2),
        .timeout_cycles (timeout2),
        .clk_div        (clk_div2),
        .done           (done2),
        .locked         (locked2),
        .err_code       (err_code2),
        .busy           (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; stimulus changes 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (half_rate) enable = ~enable;
        else           enable = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n falls, hi cycles high then lo cycles low; returns right after the last fall edge.
    task automatic run_falls(input int n, input int hi, input int lo, input bit poke);
        for (int i = 0; i < n; i++) begin
            training = 1'b1;
            repeat (hi) tick();
            if (i == n - 1) begin
                done_pre = done;
                busy_pre = busy;
            end
            training = 1'b0;
            tick();
            if (i < n - 1) begin
                if (poke && i == 4) start = 1'b1;
                tick();
                start = 1'b0;
                repeat (lo - 2) tick();
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int ndone;
        int cyc;
        n_tests        = 0;
        n_fail         = 0;
        half_rate      = 1'b0;
        rst_n          = 1'b0;
        start          = 1'b0;
        enable         = 1'b1;
        training       = 1'b0;
        timeout_cycles = 16'd0;
        start2         = 1'b0;
        training2      = 1'b0;
        timeout2       = 16'd0;
        done_pre       = 1'b0;
        busy_pre       = 1'b0;

        // Reset state
        #12;
        check("rst_clk_div", 32'(clk_div), 0);
        check("rst_done", 32'(done), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err_code), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal: p=8 -> clk_div 3
        do_start();
        check("nom_busy_after_start", 32'(busy), 1);
        run_falls(9, 4, 4, 1'b0);
        check("nom_done_before", 32'(done_pre), 0);
        check("nom_busy_before", 32'(busy_pre), 1);
        check("nom_done", 32'(done), 1);
        check("nom_clk_div", 32'(clk_div), 3);
        check("nom_locked", 32'(locked), 1);
        check("nom_err", 32'(err_code), 0);
        check("nom_busy_end", 32'(busy), 0);
        tick();
        check("nom_done_pulse", 32'(done), 0);

        // Tolerance: fourth period of 12 against ref 8
        tick();
        training = 1'b1;
        do_start();
        check("tol_locked_cleared", 32'(locked), 0);
        run_falls(4, 4, 4, 1'b0);
        check("tol_done_early", 32'(done), 0);
        repeat (3) tick();
        training = 1'b1;
        repeat (8) tick();
        training = 1'b0;
        tick();
        check("tol_done", 32'(done), 1);
        check("tol_err", 32'(err_code), 1);
        check("tol_clk_div_kept", 32'(clk_div), 3);
        check("tol_locked", 32'(locked), 0);

        // Timeout: 100 cycles, line stuck high
        training       = 1'b1;
        timeout_cycles = 16'd100;
        tick();
        do_start();
        repeat (99) tick();
        check("tmo_done_at_100", 32'(done), 0);
        tick();
        check("tmo_done_at_101", 32'(done), 1);
        check("tmo_err", 32'(err_code), 3);
        check("tmo_clk_div_kept", 32'(clk_div), 3);
        timeout_cycles = 16'd0;

        // Half-rate strobe: 8 enabled cycles per period
        half_rate = 1'b1;
        training  = 1'b1;
        tick();
        tick();
        do_start();
        run_falls(9, 8, 8, 1'b0);
        cyc = 0;
        while (!done && cyc < 4) begin
            tick();
            cyc++;
        end
        check("half_done_seen", 32'(done), 1);
        check("half_clk_div", 32'(clk_div), 3);
        check("half_locked", 32'(locked), 1);
        check("half_err", 32'(err_code), 0);
        half_rate = 1'b0;
        enable    = 1'b1;
        repeat (3) tick();

        // Start while busy is ignored; done timing unchanged
        training = 1'b1;
        do_start();
        run_falls(9, 4, 4, 1'b1);
        check("ign_done_before", 32'(done_pre), 0);
        check("ign_done", 32'(done), 1);
        check("ign_locked", 32'(locked), 1);
        tick();
        tick();
        check("ign_no_restart", 32'(busy), 0);
        check("ign_done_once", 32'(done), 0);

        // Asynchronous reset mid-measure loses clk_div
        training = 1'b1;
        do_start();
        run_falls(3, 4, 4, 1'b0);
        tick();
        check("abort_busy_pre", 32'(busy), 1);
        check("abort_clk_div_pre", 32'(clk_div), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_clk_div", 32'(clk_div), 0);
        check("abort_locked", 32'(locked), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_err", 32'(err_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Watchdog disabled: no termination in 10000 cycles
        training = 1'b1;
        do_start();
        ndone = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (done) ndone++;
        end
        check("nowd_done_count", 32'(ndone), 0);
        check("nowd_busy", 32'(busy), 1);
        apply_reset();
        check("nowd_reset_busy", 32'(busy), 0);

        // Overflow on the 4-bit divider instance
        training2 = 1'b1;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("ovf_busy", 32'(busy2), 1);
        training2 = 1'b0;
        tick();
        cyc = 0;
        while (!done2 && cyc < 60) begin
            tick();
            cyc++;
        end
        check("ovf_done_seen", 32'(done2), 1);
        check("ovf_not_early", 32'(cyc >= 30), 1);
        check("ovf_err", 32'(err_code2), 2);
        check("ovf_locked", 32'(locked2), 0);
        check("ovf_clk_div", 32'(clk_div2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
